// File: rtl/rot_share_arb.sv
// rot_share_arb: two-requester arbiter sharing one 16-bit rotate-left core.
// ROL/SLL/ROR/SRA are remapped onto the core; results land in a one-entry valid/ready stage.
module rot_share_arb #(
    parameter bit RR_EN   = 1'b1,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [15:0]        req0_data,
    input  logic [3:0]         req0_amt,
    input  logic [1:0]         req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [15:0]        req1_data,
    input  logic [3:0]         req1_amt,
    input  logic [1:0]         req1_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_data,
    output logic               rsp_id,
    output logic [STALL_W-1:0] stall_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t             state_q;
    logic [15:0]        rsp_data_q;
    logic               rsp_id_q;
    logic               last_q;
    logic [STALL_W-1:0] stall_q;

    logic        can_accept, g0, g1, hs;
    logic [15:0] din, rot, sll_mask, sra_fill, result_d;
    logic [3:0]  amt, rot_amt;
    logic [1:0]  op;

    assign can_accept = (state_q == EMPTY) | rsp_ready;
    assign g1 = req1_valid & (~req0_valid | (RR_EN & ~last_q));
    assign g0 = req0_valid & ~g1;
    assign req0_ready = ~rst & g0 & can_accept;
    assign req1_ready = ~rst & g1 & can_accept;
    assign hs = req0_ready | req1_ready;

    assign din = g1 ? req1_data : req0_data;
    assign amt = g1 ? req1_amt  : req0_amt;
    assign op  = g1 ? req1_op   : req0_op;

    // right rotations become a left rotation by (16-s) mod 16
    assign rot_amt = op[1] ? 4'd0 - amt : amt;

    always_comb begin
        rot = din;
        for (int i = 0; i < 4; i++)
            rot = rot_amt[i] ? (rot << (1 << i)) | (rot >> (16 - (1 << i))) : rot;
    end

    assign sll_mask = 16'hFFFF << amt;
    assign sra_fill = ~(16'hFFFF >> amt);
    assign result_d = op == OP_SLL ? rot & sll_mask :
                      op == OP_SRA ? (rot & ~sra_fill) | (sra_fill & {16{din[15]}}) : rot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            last_q     <= 1'b1;
            stall_q    <= '0;
        end else begin
            if (hs) begin
                state_q    <= FULL;
                rsp_data_q <= result_d;
                rsp_id_q   <= g1;
                last_q     <= g1;
            end else if (rsp_ready) begin
                state_q <= EMPTY;
            end
            if (state_q == FULL && !rsp_ready && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign rsp_valid = state_q == FULL;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_rot_share_arb.sv
// tb_rot_share_arb: checks a round-robin and a fixed-priority instance against a
// cycle-level reference model with directed steps followed by random traffic.
module tb_rot_share_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rsp_ready;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic [1:0]  req0_op, req1_op;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rvalid [2];
    logic        rid [2];
    logic [15:0] rdata [2];
    logic [7:0]  stall [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rot_share_arb #(.RR_EN(g == 0), .STALL_W(8)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(req0_valid), .req0_ready(rdy0[g]), .req0_data(req0_data),
            .req0_amt(req0_amt), .req0_op(req0_op),
            .req1_valid(req1_valid), .req1_ready(rdy1[g]), .req1_data(req1_data),
            .req1_amt(req1_amt), .req1_op(req1_op),
            .rsp_valid(rvalid[g]), .rsp_ready(rsp_ready), .rsp_data(rdata[g]),
            .rsp_id(rid[g]), .stall_cnt(stall[g])
        );
    end

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state; index 0 = round-robin instance, 1 = fixed priority
    logic        m_valid [2];
    logic        m_id [2];
    logic [15:0] m_data [2];
    int          m_stall [2];
    int          m_last [2];
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;
    logic [15:0] snap;

    function automatic logic [15:0] ref_op(logic [15:0] d, logic [3:0] s, logic [1:0] op);
        logic [15:0] r;
        r = '0;
        case (op)
            2'd0: for (int i = 0; i < 16; i++) r[(i + int'(s)) % 16] = d[i];
            2'd1: r = d << s;
            2'd2: for (int i = 0; i < 16; i++) r[i] = d[(i + int'(s)) % 16];
            default: r = 16'($signed(d) >>> s);
        endcase
        return r;
    endfunction

    function automatic int grant(int k);
        if (req0_valid && req1_valid) return (k == 0 && m_last[k] == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic exp_ready(int k, int who);
        return !rst && (!m_valid[k] || rsp_ready) && grant(k) == who;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int g;
            logic can, stl;
            g   = grant(k);
            can = !m_valid[k] || rsp_ready;
            stl = m_valid[k] && !rsp_ready;
            if (k == 0) begin
                hs0 = !rst && can && g == 0;
                hs1 = !rst && can && g == 1;
            end
            if (rst) begin
                m_valid[k] = 1'b0; m_data[k] = '0; m_id[k] = 1'b0;
                m_stall[k] = 0; m_last[k] = 1;
            end else begin
                if (can && g >= 0) begin
                    m_valid[k] = 1'b1;
                    m_id[k]    = (g == 1);
                    m_last[k]  = g;
                    m_data[k]  = g == 1 ? ref_op(req1_data, req1_amt, req1_op)
                                        : ref_op(req0_data, req0_amt, req0_op);
                end else if (rsp_ready) begin
                    m_valid[k] = 1'b0;
                end
                if (stl && m_stall[k] < 255) m_stall[k]++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req0_ready[%0d]", k), 16'(rdy0[k]), 16'(exp_ready(k, 0)));
            chk($sformatf("req1_ready[%0d]", k), 16'(rdy1[k]), 16'(exp_ready(k, 1)));
            chk($sformatf("rsp_valid[%0d]", k), 16'(rvalid[k]), 16'(m_valid[k]));
            chk($sformatf("stall_cnt[%0d]", k), 16'(stall[k]), 16'(m_stall[k]));
            if (m_valid[k]) begin
                chk($sformatf("rsp_data[%0d]", k), rdata[k], m_data[k]);
                chk($sformatf("rsp_id[%0d]", k), 16'(rid[k]), 16'(m_id[k]));
            end
        end
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic one(int who, logic [15:0] d, logic [3:0] a, logic [1:0] o, logic [15:0] exp);
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = (who == 0); req1_valid = (who == 1);
        if (who == 0) begin req0_data = d; req0_amt = a; req0_op = o; end
        else          begin req1_data = d; req1_amt = a; req1_op = o; end
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk($sformatf("direct_data op%0d", o), rdata[0], exp);
        chk("direct_id", 16'(rid[1]), 16'(who));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_id[k] = 1'b0; m_data[k] = '0; m_stall[k] = 0; m_last[k] = 1;
        end
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h1234; req0_amt = 4'd2; req0_op = 2'd0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0; req1_op = '0;
        repeat (2) cycle();
        chk("reset_valid", 16'(rvalid[0]), 16'h0);
        chk("reset_data", rdata[0], 16'h0);
        chk("reset_stall", 16'(stall[0]), 16'h0);

        one(0, 16'h8001, 4'd1, 2'd0, 16'h0003);
        one(1, 16'h00FF, 4'd4, 2'd1, 16'h0FF0);
        one(0, 16'h0001, 4'd1, 2'd2, 16'h8000);
        one(1, 16'h8000, 4'd3, 2'd3, 16'hF000);
        for (int o = 0; o < 4; o++) one(o % 2, 16'hA5C3, 4'd0, 2'(o), 16'hA5C3);
        one(0, 16'h8001, 4'd15, 2'd3, 16'hFFFF);

        req0_valid = 1'b1; req0_data = 16'h0F0F; req0_amt = 4'd3; req0_op = 2'd0;
        req1_valid = 1'b1; req1_data = 16'h1111; req1_amt = 4'd1; req1_op = 2'd1;
        repeat (6) cycle();
        chk("fixed_prio_id", 16'(rid[1]), 16'h0);

        rst = 1'b1; cycle();
        rst = 1'b0; req1_valid = 1'b0; cycle();
        rsp_ready = 1'b0; req1_valid = 1'b1;
        snap = rdata[0];
        repeat (5) cycle();
        chk("stall_5", 16'(stall[0]), 16'd5);
        chk("stall_hold", rdata[0], snap);
        rsp_ready = 1'b1; cycle();
        chk("zero_bubble_valid", 16'(rvalid[0]), 16'h1);
        chk("zero_bubble_id", 16'(rid[0]), 16'h1);

        rsp_ready = 1'b0; req1_valid = 1'b0;
        rst = 1'b1; cycle();
        chk("rst_full_valid", 16'(rvalid[0]), 16'h0);
        chk("rst_full_stall", 16'(stall[0]), 16'h0);
        rst = 1'b0; rsp_ready = 1'b1; req1_valid = 1'b1; cycle();
        chk("tie_after_reset", 16'(rid[0]), 16'h0);

        req1_valid = 1'b0; rsp_ready = 1'b0; req0_valid = 1'b0;
        repeat (300) cycle();
        chk("stall_sat0", 16'(stall[0]), 16'd255);
        chk("stall_sat1", 16'(stall[1]), 16'd255);
        rsp_ready = 1'b1; cycle();

        repeat (400) begin
            if (!req0_valid || hs0) begin
                req0_valid = 1'($urandom_range(0, 1));
                if (req0_valid) begin
                    req0_data = 16'($urandom); req0_amt = 4'($urandom); req0_op = 2'($urandom);
                end else begin
                    req0_data = 'x; req0_amt = 'x; req0_op = 'x;
                end
            end
            if (!req1_valid || hs1) begin
                req1_valid = 1'($urandom_range(0, 1));
                if (req1_valid) begin
                    req1_data = 16'($urandom); req1_amt = 4'($urandom); req1_op = 2'($urandom);
                end else begin
                    req1_data = 'x; req1_amt = 'x; req1_op = 'x;
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 99) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rot_share_arb.md
Name: rot_share_arb

Overview:
- Arbitrated front end for the 16-bit, 4-stage mux-based rotate-left core.
- Shares one rotator between two requesters: req0 is the execute-stage ALU shift path; req1 is the memory byte-align/aux path.
- Sequences ROL/SLL/ROR/SRA on top of the rotate-left-only datapath by remapping the amount and masking the result.
- Registers each result into a one-entry output stage with a valid/ready handshake and an ID tag.

Parameters:
- RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, req0 always wins.
- STALL_W, default 8: width of the saturating backpressure counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_data  in  16  operand.
- req0_amt  in  4  shift/rotate amount, 0..15.
- req0_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRA.
- req1_valid / req1_ready / req1_data / req1_amt / req1_op: same widths and meaning, for requester 1.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  16  result.
- rsp_id  out  1  requester index that produced the result.
- stall_cnt  out  STALL_W  count of cycles with rsp_valid=1 and rsp_ready=0; saturates.

Behaviour:
- Reset, synchronous, active-high, takes priority over all other events:
  - rsp_valid=0, rsp_data=0, rsp_id=0, stall_cnt=0, last_grant=1, so req0 wins the first tie.
  - req0_ready and req1_ready are 0 while rst=1.
  - A result held at reset is discarded, not delivered.
- Output-stage states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY or (FULL and rsp_ready).
  - Zero-bubble: a new result can load in the same cycle the old one drains.
- Arbitration (combinational, evaluated every cycle):
  - Only one valid and can_accept: grant that requester.
  - Both valid and RR_EN=1: grant the requester that is not last_grant.
  - Both valid and RR_EN=0: grant req0.
  - reqN_ready = grantN & can_accept. At most one ready is high in any cycle.
  - last_grant updates only on an actual handshake (reqN_valid & reqN_ready).
- Transfer rules:
  - Requester side: a handshake occurs when reqN_valid & reqN_ready.
  - Requesters hold data, amt and op stable until ready.
  - reqN_ready has no combinational path from rsp_data.
- Latency:
  - Handshake in cycle N gives rsp_valid=1 with the result in cycle N+1.
  - Throughput is one result per cycle while rsp_ready=1.
- Op mapping onto the rotate-left core (amount s):
  - ROL: rotl(data, s).
  - ROR: rotl(data, (16-s) mod 16). Width is 4 bits, so s=0 gives rotation 0.
  - SLL: rotl(data, s) AND mask, where mask clears the low s bits.
  - SRA: rotl(data, (16-s) mod 16), then the upper s bits are replaced with data[15].
  - s=0 returns data unchanged for every op.
- FULL and rsp_ready=0:
  - rsp_data and rsp_id are held stable.
  - Both reqN_ready are 0.
  - stall_cnt increments by 1, stopping at 2^STALL_W-1.
- FULL and rsp_ready=1 with no new request: state goes to EMPTY and rsp_valid=0 next cycle.
- Invalid requests are ignored. X on an unused requester's data must not propagate into rsp_data.

Test Plan:
- Reset, then req0 ROL data=0x8001 amt=1 with rsp_ready=1 -> req0_ready=1 in cycle N; rsp_valid=1, rsp_data=0x0003, rsp_id=0 in cycle N+1.
- req1 SLL 0x00FF amt=4 -> rsp_data 0x0FF0. req0 ROR 0x0001 amt=1 -> 0x8000. req1 SRA 0x8000 amt=3 -> 0xF000. Any op with amt=0 on 0xA5C3 -> 0xA5C3.
- Both requesters valid every cycle, RR_EN=1, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id alternates; with RR_EN=0 -> req0 is granted every cycle and req1 starves.
- rsp_ready held 0 for 5 cycles with a result held -> both reqN_ready stay 0, rsp_data stays stable, stall_cnt=5. Then rsp_ready=1 -> result drains and a pending request loads in the same cycle with no bubble.
- rst asserted while FULL with req0_valid=1 -> next cycle rsp_valid=0 and stall_cnt=0. After release, a tie is granted to req0 first.
- Hold backpressure for 300 cycles with STALL_W=8 -> stall_cnt saturates at 255 and does not wrap.
